// File: rtl/ins_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// ins_dispatch_pkg
// Shared constants for the instruction dispatcher:
//   - instruction type codes held in bits [63:62]
//   - bit positions of the CONF (layer configuration) fields
//   - dispatcher FSM state encoding
//   - layer configuration record and a decoder from a CONF word
// No ports; imported by ins_dispatch and ins_out_cnt.
// ---------------------------------------------------------------------------
package ins_dispatch_pkg;

  // Instruction type codes, field [63:62]
  localparam logic [1:0] INS_T_LOAD = 2'b00;
  localparam logic [1:0] INS_T_CALC = 2'b01;
  localparam logic [1:0] INS_T_SAVE = 2'b10;
  localparam logic [1:0] INS_T_CONF = 2'b11;

  localparam int TYPE_HI     = 63;
  localparam int TYPE_LO     = 62;

  // CONF field positions
  localparam int CF_LTYPE_HI = 61;
  localparam int CF_LTYPE_LO = 58;
  localparam int CF_POOL     = 57;
  localparam int CF_RELU     = 56;
  localparam int CF_ICH_HI   = 55;
  localparam int CF_ICH_LO   = 52;
  localparam int CF_OCH_HI   = 51;
  localparam int CF_OCH_LO   = 48;
  localparam int CF_IW_HI    = 47;
  localparam int CF_IW_LO    = 40;
  localparam int CF_OW_HI    = 39;
  localparam int CF_OW_LO    = 32;

  // Dispatcher FSM states
  typedef logic [1:0] disp_state_t;
  localparam disp_state_t S_FETCH = 2'd0;
  localparam disp_state_t S_CHECK = 2'd1;
  localparam disp_state_t S_ISSUE = 2'd2;

  typedef struct packed {
    logic [3:0] layer_type;
    logic       pooling;
    logic       relu;
    logic [3:0] in_ch_seg;
    logic [3:0] out_ch_seg;
    logic [7:0] in_img_w;
    logic [7:0] out_img_w;
  } layer_cfg_t;

  function automatic layer_cfg_t conf_decode(input logic [63:0] w);
    layer_cfg_t c;
    c.layer_type = w[CF_LTYPE_HI:CF_LTYPE_LO];
    c.pooling    = w[CF_POOL];
    c.relu       = w[CF_RELU];
    c.in_ch_seg  = w[CF_ICH_HI:CF_ICH_LO];
    c.out_ch_seg = w[CF_OCH_HI:CF_OCH_LO];
    c.in_img_w   = w[CF_IW_HI:CF_IW_LO];
    c.out_img_w  = w[CF_OW_HI:CF_OW_LO];
    return c;
  endfunction

endpackage

// File: rtl/ins_dispatch_out_cnt.sv
// ---------------------------------------------------------------------------
// ins_out_cnt
// Outstanding-instruction counter for one engine.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   inc           instruction handed to the engine this cycle
//   dec           engine reports one instruction finished this cycle
//   cnt           current outstanding count
//   underflow     dec seen while the count is already 0 (combinational)
// inc and dec together leave the count unchanged. A dec at 0 is ignored
// (only a simultaneous inc is applied) and flagged on underflow.
// ---------------------------------------------------------------------------
module ins_out_cnt
  import ins_dispatch_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign underflow = dec && (cnt_q == '0);
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (underflow) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ins_dispatch.sv
// ---------------------------------------------------------------------------
// ins_dispatch
// In-order dispatcher from the 64-bit instruction stream to the load, calc
// and save engines. One instruction is held at a time in IR; it is checked
// against the per-engine outstanding counters and then either handed to its
// engine (LOAD/CALC/SAVE) or applied to the layer config registers (CONF).
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   ins, ins_valid, ins_ready instruction input stream
//   ld_ins/ld_valid/ld_ready  load engine request, ld_done finish pulse
//   cl_ins/cl_valid/cl_ready  calc engine request, cl_done finish pulse
//   sv_ins/sv_valid/sv_ready  save engine request, sv_done finish pulse
//   layer_type .. out_img_w   latched CONF fields
//   idle                      fetching, nothing outstanding, nothing offered
//   err                       sticky: done pulse with that counter at 0
//   dbg_state                 current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised, valid and the payload stay unchanged until
// that transfer; valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
module ins_dispatch
  import ins_dispatch_pkg::*;
#(
  parameter int INST_W  = 64,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] ins,
  input  logic              ins_valid,
  output logic              ins_ready,
  output logic [INST_W-1:0] ld_ins,
  output logic              ld_valid,
  input  logic              ld_ready,
  input  logic              ld_done,
  output logic [INST_W-1:0] cl_ins,
  output logic              cl_valid,
  input  logic              cl_ready,
  input  logic              cl_done,
  output logic [INST_W-1:0] sv_ins,
  output logic              sv_valid,
  input  logic              sv_ready,
  input  logic              sv_done,
  output logic [3:0]        layer_type,
  output logic              pooling,
  output logic              relu,
  output logic [3:0]        in_ch_seg,
  output logic [3:0]        out_ch_seg,
  output logic [7:0]        in_img_w,
  output logic [7:0]        out_img_w,
  output logic              idle,
  output logic              err,
  output logic [1:0]        dbg_state
);

  disp_state_t       state_q, state_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              ins_ready_q, ins_ready_d;
  logic              ld_valid_q, ld_valid_d;
  logic              cl_valid_q, cl_valid_d;
  logic              sv_valid_q, sv_valid_d;
  logic [INST_W-1:0] ld_ins_q, ld_ins_d;
  logic [INST_W-1:0] cl_ins_q, cl_ins_d;
  logic [INST_W-1:0] sv_ins_q, sv_ins_d;
  layer_cfg_t        cfg_q, cfg_d;
  logic              err_q, err_d;

  logic              ld_hs, cl_hs, sv_hs;
  logic [CNT_W-1:0]  ld_cnt, cl_cnt, sv_cnt;
  logic              ld_uf, cl_uf, sv_uf;
  logic [CNT_W-1:0]  ld_eff, cl_eff, sv_eff;
  logic [1:0]        ir_type;
  logic              clear;

  assign ld_hs = ld_valid_q && ld_ready;
  assign cl_hs = cl_valid_q && cl_ready;
  assign sv_hs = sv_valid_q && sv_ready;

  ins_out_cnt #(.CNT_W(CNT_W)) u_ld_cnt (
    .clk(clk), .rst(rst), .inc(ld_hs), .dec(ld_done), .cnt(ld_cnt), .underflow(ld_uf)
  );
  ins_out_cnt #(.CNT_W(CNT_W)) u_cl_cnt (
    .clk(clk), .rst(rst), .inc(cl_hs), .dec(cl_done), .cnt(cl_cnt), .underflow(cl_uf)
  );
  ins_out_cnt #(.CNT_W(CNT_W)) u_sv_cnt (
    .clk(clk), .rst(rst), .inc(sv_hs), .dec(sv_done), .cnt(sv_cnt), .underflow(sv_uf)
  );

  // Hazard check sees this cycle's done pulses so an instruction waiting on
  // the last outstanding job goes out on the same edge the counter drops.
  // No handshake can coincide with S_CHECK, so only dec matters here.
  assign ld_eff = (ld_done && ld_cnt != '0) ? ld_cnt - 1'b1 : ld_cnt;
  assign cl_eff = (cl_done && cl_cnt != '0) ? cl_cnt - 1'b1 : cl_cnt;
  assign sv_eff = (sv_done && sv_cnt != '0) ? sv_cnt - 1'b1 : sv_cnt;

  assign ir_type = ir_q[TYPE_HI:TYPE_LO];

  // LOAD must not overwrite buffers a SAVE still reads; CALC needs loads
  // complete; SAVE needs loads and calcs complete; CONF needs everything idle.
  always_comb begin
    clear = 1'b0;
    case (ir_type)
      INS_T_LOAD: clear = (sv_eff == '0) && (ld_eff < CNT_W'(MAX_OUT));
      INS_T_CALC: clear = (ld_eff == '0) && (cl_eff < CNT_W'(MAX_OUT));
      INS_T_SAVE: clear = (ld_eff == '0) && (cl_eff == '0) && (sv_eff < CNT_W'(MAX_OUT));
      default:    clear = (ld_eff == '0) && (cl_eff == '0) && (sv_eff == '0);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ins_ready_d = ins_ready_q;
    ld_valid_d  = ld_valid_q;
    cl_valid_d  = cl_valid_q;
    sv_valid_d  = sv_valid_q;
    ld_ins_d    = ld_ins_q;
    cl_ins_d    = cl_ins_q;
    sv_ins_d    = sv_ins_q;
    cfg_d       = cfg_q;
    err_d       = err_q || ld_uf || cl_uf || sv_uf;

    case (state_q)
      S_FETCH: begin
        if (ins_valid && ins_ready_q) begin
          ir_d        = ins;
          ins_ready_d = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (clear) begin
          case (ir_type)
            INS_T_LOAD: begin
              ld_valid_d = 1'b1;
              ld_ins_d   = ir_q;
              state_d    = S_ISSUE;
            end
            INS_T_CALC: begin
              cl_valid_d = 1'b1;
              cl_ins_d   = ir_q;
              state_d    = S_ISSUE;
            end
            INS_T_SAVE: begin
              sv_valid_d = 1'b1;
              sv_ins_d   = ir_q;
              state_d    = S_ISSUE;
            end
            default: begin
              cfg_d       = conf_decode(ir_q);
              ins_ready_d = 1'b1;
              state_d     = S_FETCH;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (ld_hs || cl_hs || sv_hs) begin
          ld_valid_d  = 1'b0;
          cl_valid_d  = 1'b0;
          sv_valid_d  = 1'b0;
          ins_ready_d = 1'b1;
          state_d     = S_FETCH;
        end
      end
      default: begin
        ld_valid_d  = 1'b0;
        cl_valid_d  = 1'b0;
        sv_valid_d  = 1'b0;
        ins_ready_d = 1'b1;
        state_d     = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      ins_ready_q <= 1'b1;
      ld_valid_q  <= 1'b0;
      cl_valid_q  <= 1'b0;
      sv_valid_q  <= 1'b0;
      ld_ins_q    <= '0;
      cl_ins_q    <= '0;
      sv_ins_q    <= '0;
      cfg_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ins_ready_q <= ins_ready_d;
      ld_valid_q  <= ld_valid_d;
      cl_valid_q  <= cl_valid_d;
      sv_valid_q  <= sv_valid_d;
      ld_ins_q    <= ld_ins_d;
      cl_ins_q    <= cl_ins_d;
      sv_ins_q    <= sv_ins_d;
      cfg_q       <= cfg_d;
      err_q       <= err_d;
    end
  end

  assign ins_ready  = ins_ready_q;
  assign ld_valid   = ld_valid_q;
  assign cl_valid   = cl_valid_q;
  assign sv_valid   = sv_valid_q;
  assign ld_ins     = ld_ins_q;
  assign cl_ins     = cl_ins_q;
  assign sv_ins     = sv_ins_q;
  assign layer_type = cfg_q.layer_type;
  assign pooling    = cfg_q.pooling;
  assign relu       = cfg_q.relu;
  assign in_ch_seg  = cfg_q.in_ch_seg;
  assign out_ch_seg = cfg_q.out_ch_seg;
  assign in_img_w   = cfg_q.in_img_w;
  assign out_img_w  = cfg_q.out_img_w;
  assign err        = err_q;
  assign dbg_state  = state_q;
  assign idle       = (state_q == S_FETCH) && (ld_cnt == '0) && (cl_cnt == '0) &&
                      (sv_cnt == '0) && !ld_valid_q && !cl_valid_q && !sv_valid_q;

endmodule
